// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// opcode field position and sequential PC increment.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 21;
    localparam int PC_INC  = 4;

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// Next-PC selection: branch target (inst_pc + offset*4) or sequential inst_pc + 4.
// Purely combinational; all arithmetic wraps modulo 2^PCW.
module next_pc
    import instruction_fetch_pkg::*;
#(
    parameter int PCW = 64
) (
    input  logic [PCW-1:0] inst_pc,
    input  logic [PCW-1:0] branch_offset,
    input  logic           branch,
    input  logic           uncond_branch,
    input  logic           zero,
    output logic [PCW-1:0] pc_next
);

    logic [PCW-1:0] target;

    // Word offset to byte offset; the two bits shifted out are discarded.
    assign target = inst_pc + (branch_offset << 2);

    // uncond_branch is tested first so an unknown branch bit cannot leak in.
    always_comb begin
        pc_next = inst_pc + PCW'(PC_INC);
        if (uncond_branch) begin
            pc_next = target;
        end else if (branch && zero) begin
            pc_next = target;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches over req/ack, holds the instruction until
// downstream accepts it, then steps the PC; misaligned PCs trap until reset.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int PCW  = 64,
    parameter int IW   = 32,
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            resetl,
    input  logic [PCW-1:0]  startpc,
    output logic            imem_req,
    output logic [PCW-1:0]  imem_addr,
    input  logic            imem_ack,
    input  logic [IW-1:0]   imem_rdata,
    output logic            inst_valid,
    output logic [IW-1:0]   inst,
    output logic [10:0]     opcode,
    output logic [PCW-1:0]  inst_pc,
    input  logic            inst_ready,
    input  logic            branch,
    input  logic            uncond_branch,
    input  logic            zero,
    input  logic [PCW-1:0]  branch_offset,
    output logic [PCW-1:0]  currentpc,
    output logic            fault,
    output logic [CNTW-1:0] retired
);

    fetch_state_t   state, state_next;
    logic           fetch_done;
    logic           retire;
    logic [PCW-1:0] pc_next;

    assign fetch_done = (state == FETCH) && imem_ack;
    assign retire     = (state == HOLD) && inst_ready;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = (currentpc[1:0] != 2'b00) ? FAULT : FETCH;
            FETCH: if (imem_ack) state_next = HOLD;
            HOLD:  if (inst_ready) state_next = IDLE;
            FAULT: state_next = FAULT;
        endcase
    end

    next_pc #(.PCW(PCW)) u_next_pc (
        .inst_pc       (inst_pc),
        .branch_offset (branch_offset),
        .branch        (branch),
        .uncond_branch (uncond_branch),
        .zero          (zero),
        .pc_next       (pc_next)
    );

    // currentpc reloads from startpc for as long as reset is held.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            currentpc <= startpc;
            inst      <= '0;
            inst_pc   <= '0;
            retired   <= '0;
        end else begin
            if (fetch_done) begin
                inst    <= imem_rdata;
                inst_pc <= currentpc;
            end
            if (retire) begin
                currentpc <= pc_next;
                retired   <= retired + CNTW'(1);
            end
        end
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = currentpc;
    assign inst_valid = (state == HOLD);
    assign fault      = (state == FAULT);
    assign opcode     = inst[OPC_MSB:OPC_LSB];

endmodule
